// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong frame buffer, emits each frame bit-reversed.
// Define FFT_BITREV_MODE_EN to add a per-frame natural-order `mode` input.
module fft_bitrev_reorder #(
  parameter int LOG2N  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef FFT_BITREV_MODE_EN
  input  logic              mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [DATA_W-1:0] mem [2][N];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2N-1:0]  wr_cnt;
  logic [LOG2N-1:0]  rd_cnt;
  logic [LOG2N-1:0]  rev_cnt;
  logic [LOG2N-1:0]  rd_addr;
  logic              wr_fire;
  logic              load;
  logic              wr_end;
  logic              rd_end;

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign load     = full[rd_bank] && (!out_valid || out_ready);
  assign wr_end   = wr_fire && (wr_cnt == LAST);
  assign rd_end   = load && (rd_cnt == LAST);

  // Mirror the read counter bits to form the bit-reversed address
  always_comb begin
    rev_cnt = '0;
    for (int k = 0; k < LOG2N; k++) begin
      rev_cnt[k] = rd_cnt[LOG2N-1-k];
    end
  end

`ifdef FFT_BITREV_MODE_EN
  logic [1:0] bank_mode;

  // Capture the frame's ordering mode with its first sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_mode <= '0;
    end else if (wr_fire && (wr_cnt == '0)) begin
      bank_mode[wr_bank] <= mode;
    end
  end

  // Natural-order banks bypass the reversal
  always_comb begin
    rd_addr = bank_mode[rd_bank] ? rd_cnt : rev_cnt;
  end
`else
  // Every frame is read bit-reversed
  always_comb begin
    rd_addr = rev_cnt;
  end
`endif

  // Sample storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= in_data;
    end
  end

  // Write pointer advances per accepted sample, flips bank at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_end) begin
        wr_bank <= !wr_bank;
      end
    end
  end

  // Full flags: writer sets on frame end, reader clears after last load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_end) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_end) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // Read pointer and one-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= mem[rd_bank][rd_addr];
      out_valid <= 1'b1;
      out_last  <= rd_end;
      rd_cnt    <= rd_cnt + 1'b1;
      if (rd_end) begin
        rd_bank <= !rd_bank;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
